// File: rtl/fabric_pkg.sv
`default_nettype none
// ============================================================================
// Module   : fabric_pkg
// Purpose  : Constants and helpers shared by the routing fabric blocks.
//            - Select encodings for a switch-box output track.
//            - Side numbering.
//            - Topology identifiers.
//            - Source-track index function.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package fabric_pkg;

    // Per-track select field values
    localparam logic [1:0] SEL_OFF = 2'd0;
    localparam logic [1:0] SEL_CW  = 2'd1;
    localparam logic [1:0] SEL_OPP = 2'd2;
    localparam logic [1:0] SEL_CCW = 2'd3;

    // Side indices, numbered clockwise so that (side + sel) % 4 is the source
    localparam int SIDE_L    = 0;
    localparam int SIDE_T    = 1;
    localparam int SIDE_R    = 2;
    localparam int SIDE_B    = 3;
    localparam int NUM_SIDES = 4;

    // Topologies
    localparam int TOPO_DISJOINT = 0;
    localparam int TOPO_WILTON   = 1;

    // Track index on the source side that feeds output track i.
    // Wilton rotates the index on turns and keeps it on straight-through paths.
    function automatic int src_track_idx(input int topo, input logic [1:0] sel,
                                         input int i, input int width);
        int idx;
        idx = i;
        if (topo == TOPO_WILTON) begin
            if (sel == SEL_CW) begin
                idx = (i + 1) % width;
            end else if (sel == SEL_CCW) begin
                idx = (i + width - 1) % width;
            end
        end
        return idx;
    endfunction

endpackage
`default_nettype wire

// File: rtl/cfg_shadow_chain.sv
`default_nettype none
// ============================================================================
// Module   : cfg_shadow_chain
// Purpose  : Double-buffered serial configuration store.
//            - A shadow register shifts on i_prog_en and daisy-chains through
//              i_prog_in / o_prog_out.
//            - A commit copies the shadow into the active register only when
//              exactly CFG_BITS bits were shifted since the last commit attempt.
// Ports    : i_clk, i_rst_n (sync, active-low), i_prog_in, i_prog_en,
//            i_prog_commit, o_prog_out, o_active[CFG_BITS], o_cfg_valid,
//            o_cfg_err (sticky until the next accepted commit)
// Revision : 1.0 - initial release
// ============================================================================
module cfg_shadow_chain #(
    parameter int CFG_BITS = 24
) (
    input  logic                i_clk,
    input  logic                i_rst_n,
    input  logic                i_prog_in,
    input  logic                i_prog_en,
    input  logic                i_prog_commit,
    output logic                o_prog_out,
    output logic [CFG_BITS-1:0] o_active,
    output logic                o_cfg_valid,
    output logic                o_cfg_err
);

    // Counter must hold CFG_BITS+1 so that an overshift stays distinguishable
    localparam int                 c_CNT_W    = $clog2(CFG_BITS + 2);
    localparam logic [c_CNT_W-1:0] c_CNT_FULL = c_CNT_W'(CFG_BITS);
    localparam logic [c_CNT_W-1:0] c_CNT_SAT  = c_CNT_W'(CFG_BITS + 1);

    logic [CFG_BITS-1:0] r_shadow;
    logic [CFG_BITS-1:0] r_active;
    logic [c_CNT_W-1:0]  r_cnt;
    logic                r_valid;
    logic                r_err;
    logic                w_commit_ok;

    // A commit that collides with a shift is always rejected
    assign w_commit_ok = i_prog_commit && !i_prog_en && (r_cnt == c_CNT_FULL);

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_shadow <= '0;
            r_active <= '0;
            r_cnt    <= '0;
            r_valid  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            if (i_prog_en) begin
                r_shadow <= {i_prog_in, r_shadow[CFG_BITS-1:1]};
            end

            if (i_prog_commit) begin
                r_cnt <= '0;
            end else if (i_prog_en && (r_cnt != c_CNT_SAT)) begin
                r_cnt <= r_cnt + c_CNT_W'(1);
            end

            if (w_commit_ok) begin
                r_active <= r_shadow;
                r_valid  <= 1'b1;
                r_err    <= 1'b0;
            end else if (i_prog_commit) begin
                r_err    <= 1'b1;
            end
        end
    end

    // The first bit shifted in reaches bit 0 after CFG_BITS shifts and leaves
    // on the next one, giving a chain delay of exactly CFG_BITS shifts.
    assign o_prog_out  = r_shadow[0];
    assign o_active    = r_active;
    assign o_cfg_valid = r_valid;
    assign o_cfg_err   = r_err;

endmodule
`default_nettype wire

// File: rtl/prog_switch_box.sv
`default_nettype none
// ============================================================================
// Module   : prog_switch_box
// Purpose  : Programmable four-sided switch box, WIDTH tracks per side.
//            - Each output track picks the clockwise-next, opposite or
//              counter-clockwise-next input side, or is switched off.
//            - Disjoint or Wilton track indexing.
//            - Optional registered outputs.
// Ports    : prog_clk, prog_rst_n (sync, active-low), prog_in, prog_en,
//            prog_commit, prog_out, cfg_valid, cfg_err,
//            {l,t,r,b}_in[WIDTH], {l,t,r,b}_out[WIDTH], {l,t,r,b}_oe[WIDTH]
// Revision : 1.0 - initial release
// ============================================================================
module prog_switch_box
    import fabric_pkg::*;
#(
    parameter int WIDTH    = 3,
    parameter int TOPOLOGY = 0,
    parameter int REG_OUT  = 0
) (
    input  logic             prog_clk,
    input  logic             prog_rst_n,
    input  logic             prog_in,
    input  logic             prog_en,
    input  logic             prog_commit,
    output logic             prog_out,
    output logic             cfg_valid,
    output logic             cfg_err,
    input  logic [WIDTH-1:0] l_in,
    input  logic [WIDTH-1:0] t_in,
    input  logic [WIDTH-1:0] r_in,
    input  logic [WIDTH-1:0] b_in,
    output logic [WIDTH-1:0] l_out,
    output logic [WIDTH-1:0] t_out,
    output logic [WIDTH-1:0] r_out,
    output logic [WIDTH-1:0] b_out,
    output logic [WIDTH-1:0] l_oe,
    output logic [WIDTH-1:0] t_oe,
    output logic [WIDTH-1:0] r_oe,
    output logic [WIDTH-1:0] b_oe
);

    localparam int CFG_BITS = 8 * WIDTH;

    logic [CFG_BITS-1:0]                w_active;
    logic [NUM_SIDES-1:0][WIDTH-1:0]    w_side_in;
    logic [NUM_SIDES-1:0][WIDTH-1:0]    w_route_out;
    logic [NUM_SIDES-1:0][WIDTH-1:0]    w_route_oe;
    logic [NUM_SIDES-1:0][WIDTH-1:0]    w_out;
    logic [NUM_SIDES-1:0][WIDTH-1:0]    w_oe;

    assign w_side_in = {b_in, r_in, t_in, l_in};

    cfg_shadow_chain #(
        .CFG_BITS (CFG_BITS)
    ) u_cfg (
        .i_clk         (prog_clk),
        .i_rst_n       (prog_rst_n),
        .i_prog_in     (prog_in),
        .i_prog_en     (prog_en),
        .i_prog_commit (prog_commit),
        .o_prog_out    (prog_out),
        .o_active      (w_active),
        .o_cfg_valid   (cfg_valid),
        .o_cfg_err     (cfg_err)
    );

    // Source side and track for every (side, track, select) combination are
    // elaboration-time constants, so each output reduces to a 3:1 mux.
    for (genvar s = 0; s < NUM_SIDES; s++) begin : g_side
        for (genvar i = 0; i < WIDTH; i++) begin : g_track
            localparam int c_SIDE_CW  = (s + 1) % NUM_SIDES;
            localparam int c_SIDE_OPP = (s + 2) % NUM_SIDES;
            localparam int c_SIDE_CCW = (s + 3) % NUM_SIDES;
            localparam int c_IDX_CW   = src_track_idx(TOPOLOGY, SEL_CW,  i, WIDTH);
            localparam int c_IDX_OPP  = src_track_idx(TOPOLOGY, SEL_OPP, i, WIDTH);
            localparam int c_IDX_CCW  = src_track_idx(TOPOLOGY, SEL_CCW, i, WIDTH);

            logic [1:0] w_sel;
            assign w_sel = w_active[2*(s*WIDTH+i) +: 2];

            assign w_route_out[s][i] =
                (w_sel == SEL_CW)  ? w_side_in[c_SIDE_CW][c_IDX_CW]   :
                (w_sel == SEL_OPP) ? w_side_in[c_SIDE_OPP][c_IDX_OPP] :
                (w_sel == SEL_CCW) ? w_side_in[c_SIDE_CCW][c_IDX_CCW] :
                                     1'b0;
            assign w_route_oe[s][i] = (w_sel != SEL_OFF);
        end
    end

    if (REG_OUT != 0) begin : g_reg_out
        logic [NUM_SIDES-1:0][WIDTH-1:0] r_out;
        logic [NUM_SIDES-1:0][WIDTH-1:0] r_oe;

        always_ff @(posedge prog_clk) begin
            if (!prog_rst_n) begin
                r_out <= '0;
                r_oe  <= '0;
            end else begin
                r_out <= w_route_out;
                r_oe  <= w_route_oe;
            end
        end

        assign w_out = r_out;
        assign w_oe  = r_oe;
    end else begin : g_comb_out
        assign w_out = w_route_out;
        assign w_oe  = w_route_oe;
    end

    assign l_out = w_out[SIDE_L];
    assign t_out = w_out[SIDE_T];
    assign r_out = w_out[SIDE_R];
    assign b_out = w_out[SIDE_B];
    assign l_oe  = w_oe[SIDE_L];
    assign t_oe  = w_oe[SIDE_T];
    assign r_oe  = w_oe[SIDE_R];
    assign b_oe  = w_oe[SIDE_B];

endmodule
`default_nettype wire

// File: tb/tb_prog_switch_box.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_switch_box
// Purpose  : Self-checking bench for prog_switch_box (WIDTH=3). Three
//            instances share all inputs: disjoint/combinational, Wilton/
//            combinational, disjoint/registered. A queue-based reference
//            model tracks the configuration and predicts every output.
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_switch_box;

    localparam int W  = 3;
    localparam int NB = 24;

    logic clk = 1'b0;
    logic rst_n, pin, pen, pcom;
    logic [W-1:0] l_in, t_in, r_in, b_in;

    logic [W-1:0] lo [3];
    logic [W-1:0] to [3];
    logic [W-1:0] ro [3];
    logic [W-1:0] bo [3];
    logic [W-1:0] loe [3];
    logic [W-1:0] toe [3];
    logic [W-1:0] roe [3];
    logic [W-1:0] boe [3];
    logic         po [3];
    logic         vld [3];
    logic         err [3];

    always #5 clk = ~clk;

    prog_switch_box #(.WIDTH(W), .TOPOLOGY(0), .REG_OUT(0)) u_dis (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(pin), .prog_en(pen),
        .prog_commit(pcom), .prog_out(po[0]), .cfg_valid(vld[0]), .cfg_err(err[0]),
        .l_in(l_in), .t_in(t_in), .r_in(r_in), .b_in(b_in),
        .l_out(lo[0]), .t_out(to[0]), .r_out(ro[0]), .b_out(bo[0]),
        .l_oe(loe[0]), .t_oe(toe[0]), .r_oe(roe[0]), .b_oe(boe[0]));

    prog_switch_box #(.WIDTH(W), .TOPOLOGY(1), .REG_OUT(0)) u_wil (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(pin), .prog_en(pen),
        .prog_commit(pcom), .prog_out(po[1]), .cfg_valid(vld[1]), .cfg_err(err[1]),
        .l_in(l_in), .t_in(t_in), .r_in(r_in), .b_in(b_in),
        .l_out(lo[1]), .t_out(to[1]), .r_out(ro[1]), .b_out(bo[1]),
        .l_oe(loe[1]), .t_oe(toe[1]), .r_oe(roe[1]), .b_oe(boe[1]));

    prog_switch_box #(.WIDTH(W), .TOPOLOGY(0), .REG_OUT(1)) u_reg (
        .prog_clk(clk), .prog_rst_n(rst_n), .prog_in(pin), .prog_en(pen),
        .prog_commit(pcom), .prog_out(po[2]), .cfg_valid(vld[2]), .cfg_err(err[2]),
        .l_in(l_in), .t_in(t_in), .r_in(r_in), .b_in(b_in),
        .l_out(lo[2]), .t_out(to[2]), .r_out(ro[2]), .b_out(bo[2]),
        .l_oe(loe[2]), .t_oe(toe[2]), .r_oe(roe[2]), .b_oe(boe[2]));

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;

    // ---------------- reference model ----------------
    bit          mq[$];          // shadow contents, oldest shifted bit at [0]
    logic [23:0] m_act = '0;
    int          m_cnt = 0;
    logic        m_valid = 1'b0;
    logic        m_err = 1'b0;
    logic [11:0] m_reg_out = '0;
    logic [11:0] m_reg_oe = '0;

    function automatic logic [11:0] m_route(int topo, logic [23:0] act,
                                            logic [11:0] ins, bit want_oe);
        logic [11:0] res;
        res = '0;
        for (int s = 0; s < 4; s++) begin
            for (int i = 0; i < W; i++) begin
                logic [1:0] sel;
                int src, idx;
                sel = act[2*(s*W+i) +: 2];
                if (sel != 2'd0) begin
                    src = (s + int'(sel)) % 4;
                    idx = i;
                    if (topo == 1 && sel == 2'd1) idx = (i + 1) % W;
                    if (topo == 1 && sel == 2'd3) idx = (i + W - 1) % W;
                    res[s*W+i] = want_oe ? 1'b1 : ins[src*W+idx];
                end
            end
        end
        return res;
    endfunction

    function automatic logic [11:0] outs(int d);
        return {bo[d], ro[d], to[d], lo[d]};
    endfunction

    function automatic logic [11:0] oes(int d);
        return {boe[d], roe[d], toe[d], loe[d]};
    endfunction

    function automatic logic [23:0] img1(int side, int trk, logic [1:0] sel);
        logic [23:0] v;
        v = '0;
        v[2*(side*W+trk) +: 2] = sel;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s at cycle %0d: got %h, expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        mq.delete();
        for (int k = 0; k < NB; k++) mq.push_back(1'b0);
        m_act = '0; m_cnt = 0; m_valid = 1'b0; m_err = 1'b0;
    endtask

    // One clock: advance the model with the current inputs, take the edge,
    // then compare every DUT output against the model.
    task automatic tick();
        logic [11:0] ins, nro, nroe;
        logic [23:0] snap;
        ins  = {b_in, r_in, t_in, l_in};
        nro  = m_route(0, m_act, ins, 1'b0);
        nroe = m_route(0, m_act, ins, 1'b1);
        if (!rst_n) begin
            model_reset();
            nro = '0; nroe = '0;
        end else begin
            if (pcom) begin
                if (!pen && m_cnt == NB) begin
                    for (int j = 0; j < NB; j++) snap[j] = mq[j];
                    m_act = snap; m_valid = 1'b1; m_err = 1'b0;
                end else begin
                    m_err = 1'b1;
                end
            end
            if (pen) begin
                mq.push_back(pin);
                void'(mq.pop_front());
            end
            if (pcom) m_cnt = 0;
            else if (pen && m_cnt < NB + 1) m_cnt++;
        end
        m_reg_out = nro;
        m_reg_oe  = nroe;
        @(posedge clk);
        #1;
        cyc++;
        ins = {b_in, r_in, t_in, l_in};
        for (int d = 0; d < 3; d++) begin
            check("prog_out",  32'(po[d]),  32'(mq[0]));
            check("cfg_valid", 32'(vld[d]), 32'(m_valid));
            check("cfg_err",   32'(err[d]), 32'(m_err));
        end
        check("dis_out", 32'(outs(0)), 32'(m_route(0, m_act, ins, 1'b0)));
        check("dis_oe",  32'(oes(0)),  32'(m_route(0, m_act, ins, 1'b1)));
        check("wil_out", 32'(outs(1)), 32'(m_route(1, m_act, ins, 1'b0)));
        check("wil_oe",  32'(oes(1)),  32'(m_route(1, m_act, ins, 1'b1)));
        check("reg_out", 32'(outs(2)), 32'(m_reg_out));
        check("reg_oe",  32'(oes(2)),  32'(m_reg_oe));
    endtask

    task automatic shift_bits(logic [63:0] d, int n);
        for (int k = 0; k < n; k++) begin
            pin = d[k]; pen = 1'b1;
            tick();
        end
        pen = 1'b0; pin = 1'b0;
    endtask

    task automatic do_commit();
        pcom = 1'b1;
        tick();
        pcom = 1'b0;
    endtask

    task automatic rand_inputs();
        {b_in, r_in, t_in, l_in} = 12'($urandom);
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        int          side;
        int          trk;
        logic [1:0]  sel;
        logic [11:0] ins;      // {b, r, t, l}
        logic [2:0]  exp_dis;  // expected out on the programmed side
        logic [2:0]  exp_wil;
    } vec_t;

    vec_t tbl[7];

    initial begin
        logic [63:0] pat;
        logic [11:0] e;

        tbl[0] = '{0, 1, 2'd2, {3'b000, 3'b010, 3'b000, 3'b000}, 3'b010, 3'b010};
        tbl[1] = '{1, 0, 2'd1, {3'b000, 3'b010, 3'b000, 3'b000}, 3'b000, 3'b001};
        tbl[2] = '{1, 0, 2'd1, {3'b000, 3'b001, 3'b000, 3'b000}, 3'b001, 3'b000};
        tbl[3] = '{3, 2, 2'd3, {3'b000, 3'b010, 3'b000, 3'b000}, 3'b000, 3'b100};
        tbl[4] = '{2, 0, 2'd2, {3'b000, 3'b000, 3'b000, 3'b001}, 3'b001, 3'b001};
        tbl[5] = '{0, 2, 2'd1, {3'b000, 3'b000, 3'b001, 3'b000}, 3'b000, 3'b100};
        tbl[6] = '{1, 2, 2'd3, {3'b000, 3'b000, 3'b000, 3'b010}, 3'b000, 3'b100};

        pin = 1'b0; pen = 1'b0; pcom = 1'b0;
        rst_n = 1'b0;
        model_reset();

        // Reset with random inputs and pending controls
        for (int k = 0; k < 2; k++) begin
            rand_inputs();
            pin = 1'b1; pen = 1'b1; pcom = 1'b1;
            tick();
        end
        for (int d = 0; d < 3; d++) begin
            check("rst_out", 32'(outs(d)), 32'd0);
            check("rst_oe",  32'(oes(d)),  32'd0);
            check("rst_po",  32'(po[d]),   32'd0);
            check("rst_vld", 32'(vld[d]),  32'd0);
            check("rst_err", 32'(err[d]),  32'd0);
        end
        pin = 1'b0; pen = 1'b0; pcom = 1'b0;
        rst_n = 1'b1;
        rand_inputs();
        tick(); tick();
        check("post_rst_out", 32'(outs(0) | outs(1) | outs(2)), 32'd0);

        // Table: program one route per entry, drive inputs, compare
        foreach (tbl[v]) begin
            shift_bits(64'(img1(tbl[v].side, tbl[v].trk, tbl[v].sel)), NB);
            do_commit();
            {b_in, r_in, t_in, l_in} = tbl[v].ins;
            tick();
            e = 12'(tbl[v].exp_dis) << (3 * tbl[v].side);
            check("tbl_dis_out", 32'(outs(0)), 32'(e));
            e = 12'(tbl[v].exp_wil) << (3 * tbl[v].side);
            check("tbl_wil_out", 32'(outs(1)), 32'(e));
            check("tbl_oe", 32'(oes(1)), 32'(12'd1 << (3 * tbl[v].side + tbl[v].trk)));
            check("tbl_vld", 32'(vld[0]), 32'd1);
        end

        // Short / over / exact shift. Active is still t[2] <- l (disjoint: l[2]).
        {b_in, r_in, t_in, l_in} = {3'b000, 3'b010, 3'b000, 3'b010};
        shift_bits(64'(img1(0, 1, 2'd2)), NB - 1);
        do_commit();
        check("short_err", 32'(err[0]), 32'd1);
        check("short_oe",  32'(oes(0)), 32'h020);
        check("short_wil", 32'(outs(1)), 32'h020);
        shift_bits(64'(img1(0, 1, 2'd2)), NB + 1);
        do_commit();
        check("over_err", 32'(err[0]), 32'd1);
        check("over_oe",  32'(oes(0)), 32'h020);
        shift_bits(64'(img1(0, 1, 2'd2)), NB);
        do_commit();
        check("exact_err", 32'(err[0]), 32'd0);
        check("exact_out", 32'(outs(0)), 32'h002);
        check("exact_oe",  32'(oes(0)),  32'h002);

        // Chain passthrough with a 5-cycle pause
        pat = {32'($urandom), 32'($urandom)};
        for (int k = 1; k <= 2 * NB; k++) begin
            pin = pat[k-1]; pen = 1'b1;
            tick();
            if (k >= NB) check("chain", 32'(po[0]), 32'(pat[k-NB]));
            if (k == 30) begin
                pen = 1'b0;
                for (int p = 0; p < 5; p++) begin
                    tick();
                    check("chain_hold", 32'(po[0]), 32'(pat[6]));
                end
            end
        end
        pen = 1'b0;
        check("chain_active", 32'(outs(0)), 32'h002);

        // Registered outputs: collision, commit latency, input latency.
        // Active is l[1] <- r, r_in = 010.
        do_commit();                      // clears the saturated counter
        {b_in, r_in, t_in, l_in} = {3'b000, 3'b010, 3'b000, 3'b001};
        shift_bits(64'(img1(2, 0, 2'd2)), NB - 1);
        pin = 1'b0; pen = 1'b1; pcom = 1'b1;
        tick();
        pen = 1'b0; pcom = 1'b0;
        check("coll_err", 32'(err[2]), 32'd1);
        check("coll_vld", 32'(vld[2]), 32'd1);
        check("coll_reg", 32'(outs(2)), 32'h002);
        shift_bits(64'(img1(2, 0, 2'd2)), NB);
        do_commit();
        check("commit_comb", 32'(outs(0)), 32'h040);
        check("commit_reg_old", 32'(outs(2)), 32'h002);
        tick();
        check("commit_reg_new", 32'(outs(2)), 32'h040);
        check("commit_reg_oe",  32'(oes(2)),  32'h040);
        l_in = 3'b000;
        #1;
        check("toggle_comb", 32'(outs(0)), 32'd0);
        check("toggle_reg_hold", 32'(outs(2)), 32'h040);
        tick();
        check("toggle_reg", 32'(outs(2)), 32'd0);

        // Randomized bursts against the model
        for (int b = 0; b < 80; b++) begin
            int len;
            len = ($urandom_range(0, 3) == 0) ? int'($urandom_range(20, 28)) : NB;
            for (int k = 0; k < len; k++) begin
                rand_inputs();
                pin   = 1'($urandom);
                pen   = ($urandom_range(0, 9) != 0);
                pcom  = ($urandom_range(0, 59) == 0);
                rst_n = ($urandom_range(0, 399) != 0);
                tick();
            end
            rst_n = 1'b1; pen = 1'b0; pcom = 1'b1;
            rand_inputs();
            tick();
            pcom = 1'b0;
            for (int k = 0; k < int'($urandom_range(1, 4)); k++) begin
                rand_inputs();
                tick();
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
